alu_seq: RTL

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_pkg.sv | 45 ++++
 rtl/alu_muldiv_iter.sv | 110 +++++++++++
 rtl/alu_seq.sv | 122 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// ------------------------------------------------------------------
// alu_pkg: op codes, branch-compare selects and FSM states for alu_seq.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_SLL   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_SRL   = 4'b0100;
  localparam logic [3:0] OP_SRA   = 4'b0101;
  localparam logic [3:0] OP_OR    = 4'b0110;
  localparam logic [3:0] OP_AND   = 4'b0111;
  localparam logic [3:0] OP_LUI   = 4'b1000;
  localparam logic [3:0] OP_MUL   = 4'b1001;
  localparam logic [3:0] OP_MULH  = 4'b1010;
  localparam logic [3:0] OP_MULHU = 4'b1011;
  localparam logic [3:0] OP_DIV   = 4'b1100;
  localparam logic [3:0] OP_DIVU  = 4'b1101;
  localparam logic [3:0] OP_REM   = 4'b1110;
  localparam logic [3:0] OP_REMU  = 4'b1111;

  localparam logic [2:0] FS_EQ  = 3'b000;
  localparam logic [2:0] FS_NE  = 3'b001;
  localparam logic [2:0] FS_LT  = 3'b100;
  localparam logic [2:0] FS_GE  = 3'b101;
  localparam logic [2:0] FS_LTU = 3'b110;
  localparam logic [2:0] FS_GEU = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_iterative(input logic [3:0] op);
    return (op >= OP_MUL);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_muldiv_iter.sv
// ------------------------------------------------------------------
// alu_muldiv_iter: radix-2 shift-add multiplier / restoring divider, one bit per cycle.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            last,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  // hi/lo hold partial product (mul) or remainder/quotient (div); dsr is multiplicand or divisor
  logic [XLEN-1:0] hi, lo, dsr;
  logic [XLEN-1:0] hi_n, lo_n;
  logic [3:0]      op_q;
  logic            neg_q, neg_r, div_zero, busy;
  logic [CW-1:0]   count;

  logic            op_signed, a_neg, b_neg, is_mul;
  logic [XLEN-1:0] a_abs, b_abs;
  logic [XLEN:0]   mul_sum, div_sh, div_diff;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0] quot, rem;

  assign op_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  assign a_neg     = op_signed & a[XLEN-1];
  assign b_neg     = op_signed & b[XLEN-1];
  assign a_abs     = a_neg ? -a : a;
  assign b_abs     = b_neg ? -b : b;
  assign is_mul    = (op_q == OP_MUL) || (op_q == OP_MULH) || (op_q == OP_MULHU);
  assign last      = busy && (count == CW'(XLEN - 1));

  always_comb begin
    mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, dsr} : {(XLEN+1){1'b0}});
    div_sh   = {hi, lo[XLEN-1]};
    div_diff = div_sh - {1'b0, dsr};
    if (is_mul) begin
      hi_n = mul_sum[XLEN:1];
      lo_n = {mul_sum[0], lo[XLEN-1:1]};
    end else if (!div_diff[XLEN]) begin
      hi_n = div_diff[XLEN-1:0];
      lo_n = {lo[XLEN-2:0], 1'b1};
    end else begin
      hi_n = div_sh[XLEN-1:0];
      lo_n = {lo[XLEN-2:0], 1'b0};
    end
  end

  // Result is formed from the step values so it is ready on the final iteration edge
  always_comb begin
    prod   = {hi_n, lo_n};
    prod_s = neg_q ? -prod : prod;
    quot   = div_zero ? {XLEN{1'b1}} : (neg_q ? -lo_n : lo_n);
    rem    = neg_r ? -hi_n : hi_n;
    case (op_q)
      OP_MUL:           result = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHU: result = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:  result = quot;
      default:          result = rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi       <= '0;
      lo       <= '0;
      dsr      <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      busy     <= 1'b0;
      count    <= '0;
    end else if (start) begin
      hi       <= '0;
      lo       <= a_abs;
      dsr      <= b_abs;
      op_q     <= op;
      neg_q    <= a_neg ^ b_neg;
      neg_r    <= a_neg;
      div_zero <= (b == '0);
      busy     <= 1'b1;
      count    <= '0;
    end else if (busy) begin
      hi <= hi_n;
      lo <= lo_n;
      if (last) begin
        busy  <= 1'b0;
        count <= '0;
      end else begin
        count <= count + CW'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
// ------------------------------------------------------------------
// alu_seq: valid/ready RISC-V ALU with branch compare; ALU_SEQ_MULDIV_EN enables iterative mul/div.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module alu_seq
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            Valid_i,
  output logic            Ready_o,
  input  logic [XLEN-1:0] OperandA_i,
  input  logic [XLEN-1:0] OperandB_i,
  input  logic [3:0]      ALUCtrl_i,
  input  logic [2:0]      Flagsel_i,
  output logic            Valid_o,
  output logic [XLEN-1:0] Result_o,
  output logic            Flag_o
);

  state_t          state, state_n;
  logic            accept, go_calc, flag_in, flag_pend, md_last;
  logic [XLEN-1:0] alu_res, md_result;
  logic [SHW-1:0]  shamt;

`ifdef ALU_SEQ_MULDIV_EN
  localparam logic MULDIV_EN = 1'b1;

  alu_muldiv_iter #(.XLEN(XLEN)) u_muldiv (
    .clk    (clk_i),
    .rst    (rst_i),
    .start  (accept && go_calc),
    .op     (ALUCtrl_i),
    .a      (OperandA_i),
    .b      (OperandB_i),
    .last   (md_last),
    .result (md_result)
  );
`else
  localparam logic MULDIV_EN = 1'b0;

  assign md_last   = 1'b0;
  assign md_result = '0;
`endif

  assign Ready_o = (state == IDLE);
  assign Valid_o = (state == DONE);
  assign accept  = Valid_i && Ready_o;
  assign go_calc = MULDIV_EN && is_iterative(ALUCtrl_i);
  assign shamt   = OperandB_i[SHW-1:0];

  // Iterative codes fall to the default and yield zero when mul/div is not built
  always_comb begin
    alu_res = '0;
    case (ALUCtrl_i)
      OP_ADD: alu_res = OperandA_i + OperandB_i;
      OP_SUB: alu_res = OperandA_i - OperandB_i;
      OP_SLL: alu_res = OperandA_i << shamt;
      OP_XOR: alu_res = OperandA_i ^ OperandB_i;
      OP_SRL: alu_res = OperandA_i >> shamt;
      OP_SRA: alu_res = $unsigned($signed(OperandA_i) >>> shamt);
      OP_OR:  alu_res = OperandA_i | OperandB_i;
      OP_AND: alu_res = OperandA_i & OperandB_i;
      OP_LUI: alu_res = OperandB_i << 12;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    flag_in = 1'b0;
    case (Flagsel_i)
      FS_EQ:  flag_in = (OperandA_i == OperandB_i);
      FS_NE:  flag_in = (OperandA_i != OperandB_i);
      FS_LT:  flag_in = ($signed(OperandA_i) <  $signed(OperandB_i));
      FS_GE:  flag_in = ($signed(OperandA_i) >= $signed(OperandB_i));
      FS_LTU: flag_in = (OperandA_i <  OperandB_i);
      FS_GEU: flag_in = (OperandA_i >= OperandB_i);
      default: flag_in = 1'b0;
    endcase
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (accept) state_n = go_calc ? CALC : DONE;
      CALC: if (md_last) state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_n;
  end

  // Outputs change only on the edge that enters DONE; the flag of an iterative op waits in flag_pend
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      Result_o  <= '0;
      Flag_o    <= 1'b0;
      flag_pend <= 1'b0;
    end else if (accept) begin
      flag_pend <= flag_in;
      if (!go_calc) begin
        Result_o <= alu_res;
        Flag_o   <= flag_in;
      end
    end else if ((state == CALC) && md_last) begin
      Result_o <= md_result;
      Flag_o   <= flag_pend;
    end
  end

endmodule

`default_nettype wire
